// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: latches two WIDTH-bit operands and adds them LSB first,
// one bit per clock, through a single full-adder slice. Reports carry-out and signed overflow.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] partial;

  logic slice_s_c;
  logic slice_co_c;

  // The time-shared full-adder slice
  always_comb begin
    slice_s_c  = a_sh[0] ^ b_sh[0] ^ carry;
    slice_co_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  end

  // Sequencer; in RUN the carry register holds the carry into the current bit,
  // so on the last bit it is the carry into the MSB used for overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      bit_cnt  <= '0;
      carry    <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      partial  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            a_sh    <= a;
            b_sh    <= b;
            carry   <= cin;
            bit_cnt <= '0;
            partial <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          partial <= {slice_s_c, partial[WIDTH-1:1]};
          a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
          carry   <= slice_co_c;
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == LAST_BIT) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            sum      <= {slice_s_c, partial[WIDTH-1:1]};
            cout     <= slice_co_c;
            overflow <= carry ^ slice_co_c;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int checks;
  int failures;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called one step after the accept edge; counts edges (accept edge = 1) until done.
  // If inj > 0, a spurious start with a=0x11 is pulsed during RUN cycle inj.
  task automatic wait_done(input int inj, output int edges_o, output int busy_o);
    int e;
    int bc;
    e  = 1;
    bc = 0;
    while (!done && e < 40) begin
      if (busy) bc++;
      if (inj > 0 && e == inj) begin
        start = 1'b1;
        a     = 8'h11;
      end else begin
        start = 1'b0;
      end
      step();
      e++;
    end
    start = 1'b0;
    if (!done) chk("done_timeout", 32'(done), 32'd1);
    edges_o = e;
    busy_o  = bc;
  endtask

  task automatic run_add(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                         input logic tc, input logic [7:0] es, input logic ec,
                         input logic eo, input int inj);
    int e;
    int bc;
    a = ta; b = tb_; cin = tc; start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
    wait_done(inj, e, bc);
    chk({tag, "_latency"}, 32'(e), 32'd9);
    chk({tag, "_busy_cycles"}, 32'(bc), 32'd8);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
    step();
    chk({tag, "_done_pulse"}, 32'({done, busy}), 32'd0);
    chk({tag, "_sum_held"}, 32'(sum), 32'(es));
  endtask

  initial begin
    int e1, e2, bc, gap;
    int idle_between;
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] full;
    logic       ovf;

    checks = 0; failures = 0;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    step();
    chk("reset_outputs", 32'({busy, done, sum, cout, overflow}), 32'd0);
    reset = 1'b0;
    step();
    step();
    chk("idle_no_start", 32'({busy, done}), 32'd0);

    run_add("t2", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0);

    // Reset during RUN after 3 RUN cycles
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("mid_run_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("reset_async_outputs", 32'({busy, done, sum, cout, overflow}), 32'd0);
    step();
    reset = 1'b0;
    e1 = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done || busy) e1++;
    end
    chk("reset_no_done", 32'(e1), 32'd0);

    run_add("t3a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    run_add("t3b", 8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1, 0);
    run_add("t4a", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 0);
    run_add("t4b_ignored_start", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 4);
    step();
    chk("t4b_no_restart", 32'({busy, done}), 32'd0);

    // Back-to-back with start held high
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    step();
    a = 8'h10; b = 8'h20;
    e1 = 1;
    while (!done && e1 < 40) begin step(); e1++; end
    chk("b2b_first_latency", 32'(e1), 32'd9);
    chk("b2b_first_sum", 32'({cout, sum}), 32'h003);
    step();
    start = 1'b0;
    chk("b2b_busy_resumes", 32'({busy, done}), 32'd2);
    e2 = 1;
    idle_between = 0;
    while (!done && e2 < 40) begin
      if (!busy) idle_between++;
      step();
      e2++;
    end
    chk("b2b_done_spacing", 32'(e2), 32'd9);
    chk("b2b_busy_no_drop", 32'(idle_between), 32'd0);
    chk("b2b_second_sum", 32'({cout, sum, overflow}), 32'h060);
    step();

    // Random operands with random gaps, including start in the DONE cycle
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      full = 9'(ra) + 9'(rb) + 9'(rc);
      ovf  = (ra[7] == rb[7]) && (full[7] != ra[7]);
      a = ra; b = rb; cin = rc; start = 1'b1;
      step();
      start = 1'b0;
      wait_done(0, e1, bc);
      chk("rand_result", 32'({full, ovf}), 32'({cout, sum, overflow}));
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
